// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants and types for the nibble-serial add/subtract controller.
// Holds the nibble width, the FSM state encoding and the index-width helper.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-nibble operation still needs a 1-bit index register.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder, purely combinational.
// The controller owns all state and feeds this adder one nibble per clock.
module ripple_carry_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that adds or subtracts WIDTH-bit operands one nibble per clock,
// LSB first, through a single shared 4-bit ripple-carry adder.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [WIDTH-1:0]    sum_reg;
    logic [WIDTH-1:0]    sum_next;
    logic                carry_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                cout_reg;
    logic                ovf_reg;

    logic [WIDTH-1:0]    a_shift;
    logic [WIDTH-1:0]    b_shift;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;
    logic                accept;
    logic                last_nib;

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_nib  = (idx_reg == IDX_W'(NIB - 1));
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;

    // Current nibble of each operand, selected by the running index.
    assign a_shift = a_reg >> (idx_reg * NIBBLE_W);
    assign b_shift = b_reg >> (idx_reg * NIBBLE_W);
    assign a_nib   = a_shift[NIBBLE_W-1:0];
    assign b_nib   = b_shift[NIBBLE_W-1:0];

    ripple_carry_adder u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Only the nibble being worked on is replaced; the rest hold.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_nib
            assign sum_next[gi*NIBBLE_W +: NIBBLE_W] =
                (state_reg == ST_RUN && idx_reg == IDX_W'(gi)) ? add_sum
                                                              : sum_reg[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_RUN;
            ST_RUN:  if (last_nib)  state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            sum_reg <= sum_next;
            if (accept) begin
                // Subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry.
                a_reg     <= in_a;
                b_reg     <= in_sub ? ~in_b : in_b;
                carry_reg <= in_sub;
                idx_reg   <= '0;
            end
            if (state_reg == ST_RUN) begin
                carry_reg <= add_cout;
                idx_reg   <= idx_reg + IDX_W'(1);
                if (last_nib) begin
                    cout_reg <= add_cout;
                    ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (add_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=4.
// Drivers push expected results; per-DUT monitors pop and compare on out_valid.
module tb_nibble_serial_add_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // WIDTH=16 instance
    logic        rst16 = 1'b1, v16 = 1'b0, sub16 = 1'b0, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        r16, ov16, co16, ovf16, busy16;
    logic [15:0] sum16;
    // WIDTH=4 instance
    logic        rst4 = 1'b1, v4 = 1'b0, sub4 = 1'b0, or4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        r4, ov4, co4, ovf4, busy4;
    logic [3:0]  sum4;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
        .in_sub(sub16), .out_valid(ov16), .out_ready(or16), .out_sum(sum16),
        .out_cout(co16), .out_ovf(ovf16), .busy(busy16));

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4),
        .in_sub(sub4), .out_valid(ov4), .out_ready(or4), .out_sum(sum4),
        .out_cout(co4), .out_ovf(ovf4), .busy(busy4));

    exp_t q16[$];
    exp_t q4[$];
    bit   rand_or16 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned/signed integer arithmetic on the whole operands.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub);
        exp_t   e;
        longint m  = longint'(1) << w;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = a[w-1] ? ua - m : ua;
        longint sb = b[w-1] ? ub - m : ub;
        longint r, sr;
        if (sub) begin
            r = ua - ub; sr = sa - sb; e.cout = (ua >= ub);
        end else begin
            r = ua + ub; sr = sa + sb; e.cout = (r >= m);
        end
        r      = (r + m) % m;
        e.sum  = 16'(r);
        e.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        e.acc  = 0;
        return e;
    endfunction

    // Issue one operation on the 16-bit DUT; expected values are pushed at accept.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input exp_t e, input bit push);
        int n = 0;
        @(posedge clk); #1;
        a16 = a; b16 = b; sub16 = sub; v16 = 1'b1;
        do begin @(negedge clk); n++; end while (!r16 && n < 200);
        if (!r16) begin
            checks++; failures++;
            $display("FAIL accept16_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            e.acc = cyc + 1;
            if (push) q16.push_back(e);
        end
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub);
        int   n = 0;
        exp_t e = model(4, {12'd0, a}, {12'd0, b}, sub);
        @(posedge clk); #1;
        a4 = a; b4 = b; sub4 = sub; v4 = 1'b1;
        do begin @(negedge clk); n++; end while (!r4 && n < 50);
        if (!r4) begin
            checks++; failures++;
            $display("FAIL accept4_timeout: in_ready stayed 0 for %0d cycles", n);
        end else begin
            e.acc = cyc + 1;
            q4.push_back(e);
        end
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    // Monitors: compare every cycle out_valid is up (so held values must stay put).
    initial begin : mon16
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (ov16) begin
                if (q16.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid16: out_valid=1 expected 0 sum=%0h", sum16);
                end else begin
                    e = q16[0];
                    check("sum16", 32'(sum16), 32'(e.sum));
                    check("cout16", 32'(co16), 32'(e.cout));
                    check("ovf16", 32'(ovf16), 32'(e.ovf));
                    check("in_ready_done16", 32'(r16), 32'd0);
                    if (!prev) check("latency16", 32'(cyc - e.acc), 32'd4);
                    if (or16) void'(q16.pop_front());
                end
            end
            prev = ov16;
        end
    end

    initial begin : mon4
        bit   prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (ov4) begin
                if (q4.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid4: out_valid=1 expected 0 sum=%0h", sum4);
                end else begin
                    e = q4[0];
                    check("sum4", 32'(sum4), 32'(e.sum[3:0]));
                    check("cout4", 32'(co4), 32'(e.cout));
                    check("ovf4", 32'(ovf4), 32'(e.ovf));
                    if (!prev) check("latency4", 32'(cyc - e.acc), 32'd1);
                    if (or4) void'(q4.pop_front());
                end
            end
            prev = ov4;
        end
    end

    initial begin : rand_ready
        forever begin
            @(posedge clk); #1;
            if (rand_or16) or16 = 1'($urandom_range(0, 1));
        end
    end

    initial begin : main
        exp_t e;
        int   n;
        logic [15:0] ra, rb;
        logic        rs;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready16", 32'(r16), 32'd0);
        check("rst_out_valid16", 32'(ov16), 32'd0);
        check("rst_busy16", 32'(busy16), 32'd0);
        check("rst_sum16", 32'(sum16), 32'd0);
        check("rst_cout_ovf16", 32'({co16, ovf16}), 32'd0);
        check("rst_in_ready4", 32'(r4), 32'd0);
        @(posedge clk); #1;
        rst16 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        check("idle_in_ready16", 32'(r16), 32'd1);

        // Directed cases with expectations written out by hand
        e = '{sum: 16'h0100, cout: 1'b0, ovf: 1'b0, acc: 0}; op16(16'h00FF, 16'h0001, 1'b0, e, 1'b1);
        e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, acc: 0}; op16(16'hFFFF, 16'h0001, 1'b0, e, 1'b1);
        e = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, acc: 0}; op16(16'h7FFF, 16'h0001, 1'b0, e, 1'b1);
        e = '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0, acc: 0}; op16(16'h0005, 16'h0007, 1'b1, e, 1'b1);
        e = '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, acc: 0}; op16(16'h8000, 16'h0001, 1'b1, e, 1'b1);

        // Backpressure: hold out_ready low, pulse in_valid with junk operands
        n = 0;
        while (q16.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        or16 = 1'b0;
        e = '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0, acc: 0}; op16(16'h1234, 16'h4321, 1'b0, e, 1'b1);
        n = 0;
        while (!ov16 && n < 20) begin @(negedge clk); n++; end
        check("bp_valid_seen", 32'(ov16), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            v16 = 1'(i % 2); a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        end
        @(posedge clk); #1;
        v16 = 1'b0; or16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_busy16", 32'(busy16), 32'd0);
        check("bp_release_valid16", 32'(ov16), 32'd0);

        // Reset during the second RUN cycle abandons the operation
        e = '{sum: 16'h0000, cout: 1'b0, ovf: 1'b0, acc: 0}; op16(16'h1111, 16'h2222, 1'b0, e, 1'b0);
        @(posedge clk); #1;
        rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        @(negedge clk);
        check("abort_busy16", 32'(busy16), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid16", 32'(ov16), 32'd0);
        end
        e = '{sum: 16'h3333, cout: 1'b0, ovf: 1'b0, acc: 0}; op16(16'h1111, 16'h2222, 1'b0, e, 1'b1);

        // Randomized operands with random output backpressure
        rand_or16 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            op16(ra, rb, rs, model(16, ra, rb, rs), 1'b1);
        end
        n = 0;
        while (q16.size() != 0 && n < 200) begin @(negedge clk); n++; end
        rand_or16 = 1'b0;
        @(posedge clk); #1;
        or16 = 1'b1;

        // WIDTH=4: exhaustive
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    op4(4'(a), 4'(b), 1'(s));

        n = 0;
        while ((q16.size() != 0 || q4.size() != 0) && n < 200) begin @(negedge clk); n++; end
        check("drain_q16", 32'(q16.size()), 32'd0);
        check("drain_q4", 32'(q4.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
